// File: rtl/cfg_bus_pkg.sv
// Shared types and constants for the firmware configuration bus (configId/configData).
// Field codes select the per-chain firmware table on the receiving block.
package cfg_bus_pkg;
    localparam logic [7:0] IDLE_ID          = 8'hFF;
    localparam logic [7:0] FIELD_OP         = 8'd0;
    localparam logic [7:0] FIELD_ADDR_RD    = 8'd1;
    localparam logic [7:0] FIELD_COND       = 8'd2;
    localparam logic [7:0] FIELD_CACHE      = 8'd3;
    localparam logic [7:0] FIELD_CACHE_ADDR = 8'd4;
    localparam int         FRAME_LEN        = 3;

    typedef struct packed {
        logic [7:0] target;
        logic [7:0] field;
        logic [7:0] chain;
        logic [7:0] value;
    } cfg_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_FIELD,
        SEND_CHAIN,
        SEND_VALUE,
        GAP
    } cfg_state_t;
endpackage

// File: rtl/cfg_cmd_fifo.sv
// Show-ahead synchronous FIFO of configuration commands; head is valid whenever !empty.
module cfg_cmd_fifo
    import cfg_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  cfg_cmd_t wr_data,
    output cfg_cmd_t rd_data,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    cfg_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/firmware_config_dispatcher.sv
// Queues host config commands and serialises each as a field/chain/value frame on the
// 8-bit config bus, starting frames only while the trace pipeline is idle.
module firmware_config_dispatcher #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         MAX_CHAINS = 4,
    parameter logic [7:0] IDLE_ID    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tracing,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_target,
    input  logic [7:0]  cmd_field,
    input  logic [7:0]  cmd_chain,
    input  logic [7:0]  cmd_value,
    output logic [7:0]  configId,
    output logic [7:0]  configData,
    output logic        busy,
    output logic        cmd_error,
    output logic [15:0] frames_sent
);
    import cfg_bus_pkg::*;

    localparam logic [8:0] MAX_CH = 9'(MAX_CHAINS);

    cfg_state_t state, next_state;
    cfg_cmd_t   head, cur;
    logic       full, empty, accept, bad_cmd, push, start;
    logic [7:0] id_d, data_d;
    logic       count_en;

    assign cmd_ready = !full;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_cmd   = (cmd_target == IDLE_ID) || (cmd_field > FIELD_CACHE_ADDR)
                     || ({1'b0, cmd_chain} >= MAX_CH);
    assign push      = accept && !bad_cmd;
    // GAP also launches the next frame, so the delimiting idle bus cycle is the only
    // dead cycle between back-to-back frames.
    assign start     = !empty && !tracing && (state == IDLE || state == GAP);

    cfg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (start),
        .wr_data ({cmd_target, cmd_field, cmd_chain, cmd_value}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (start) next_state = SEND_FIELD;
            SEND_FIELD: next_state = SEND_CHAIN;
            SEND_CHAIN: next_state = SEND_VALUE;
            SEND_VALUE: next_state = GAP;
            GAP:        next_state = start ? SEND_FIELD : IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        id_d     = IDLE_ID;
        data_d   = '0;
        count_en = 1'b0;
        busy     = (state != IDLE) || !empty;
        case (state)
            SEND_FIELD: begin id_d = cur.target; data_d = cur.field; end
            SEND_CHAIN: begin id_d = cur.target; data_d = cur.chain; end
            SEND_VALUE: begin id_d = cur.target; data_d = cur.value; count_en = 1'b1; end
            default:    ;
        endcase
    end

    // Bus word for a state is registered on the edge leaving it.
    always_ff @(posedge clk) begin
        if (reset) begin
            configId    <= IDLE_ID;
            configData  <= '0;
            cmd_error   <= 1'b0;
            frames_sent <= '0;
            cur         <= '0;
        end else begin
            configId   <= id_d;
            configData <= data_d;
            if (accept && bad_cmd)
                cmd_error <= 1'b1;
            if (count_en)
                frames_sent <= frames_sent + 16'd1;
            if (start)
                cur <= head;
        end
    end
endmodule

// File: tb/tb_firmware_config_dispatcher.sv
// Directed bench for the config bus dispatcher: frame timing, queue full, tracing hold-off,
// rejection, reset mid-frame and frame counter wrap.
module tb_firmware_config_dispatcher;
    logic        clk = 1'b0;
    logic        reset, tracing, cmd_valid, cmd_ready;
    logic [7:0]  cmd_target, cmd_field, cmd_chain, cmd_value;
    logic [7:0]  configId, configData;
    logic        busy, cmd_error;
    logic [15:0] frames_sent;
    int          nvec = 0;
    int          nerr = 0;

    firmware_config_dispatcher dut (
        .clk         (clk),
        .reset       (reset),
        .tracing     (tracing),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_field   (cmd_field),
        .cmd_chain   (cmd_chain),
        .cmd_value   (cmd_value),
        .configId    (configId),
        .configData  (configData),
        .busy        (busy),
        .cmd_error   (cmd_error),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] t, input logic [7:0] f, input logic [7:0] c,
                        input logic [7:0] v);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_field  = f;
        cmd_chain  = c;
        cmd_value  = v;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic bus(input string tag, input logic [7:0] id, input logic [7:0] data);
        check({tag, ".id"},   16'(configId),   16'(id));
        check({tag, ".data"}, 16'(configData), 16'(data));
    endtask

    // Frame data for the queue-fill test: target, field, chain, value.
    logic [7:0] fill_t [4] = '{8'd1, 8'd1, 8'd3, 8'd3};
    logic [7:0] fill_f [4] = '{8'd0, 8'd1, 8'd2, 8'd4};
    logic [7:0] fill_c [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
    logic [7:0] fill_v [4] = '{8'h10, 8'h11, 8'h12, 8'h13};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tracing = 1'b0; cmd_valid = 1'b0;
        cmd_target = '0; cmd_field = '0; cmd_chain = '0; cmd_value = '0;
        repeat (3) tick();
        bus("rst", 8'hFF, 8'h00);
        check("rst.err",    16'(cmd_error), 16'd0);
        check("rst.frames", frames_sent,    16'd0);
        check("rst.busy",   16'(busy),      16'd0);
        reset = 1'b0;
        check("rst.ready",  16'(cmd_ready), 16'd1);

        // Single command: field appears 2 edges after the push edge.
        push(8'd2, 8'd1, 8'd3, 8'h5A);
        check("t1.busy", 16'(busy), 16'd1);
        tick(); bus("t1.lat", 8'hFF, 8'h00);
        tick(); bus("t1.f", 8'd2, 8'd1);
        tick(); bus("t1.c", 8'd2, 8'd3);
        tick(); bus("t1.v", 8'd2, 8'h5A);
        check("t1.frames", frames_sent, 16'd1);
        tick(); bus("t1.gap", 8'hFF, 8'h00);
        check("t1.busy_lo", 16'(busy), 16'd0);

        // Fill the queue while tracing holds dispatch off.
        tracing = 1'b1;
        for (int k = 0; k < 4; k++) push(fill_t[k], fill_f[k], fill_c[k], fill_v[k]);
        check("t2.ready", 16'(cmd_ready), 16'd0);
        check("t2.busy",  16'(busy),      16'd1);
        tick(); bus("t2.hold", 8'hFF, 8'h00);
        tracing = 1'b0;
        tick(); bus("t2.lat", 8'hFF, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick(); bus("t2.f", fill_t[k], fill_f[k]);
            tick(); bus("t2.c", fill_t[k], fill_c[k]);
            tick(); bus("t2.v", fill_t[k], fill_v[k]);
            tick(); bus("t2.gap", 8'hFF, 8'h00);
        end
        check("t2.frames",  frames_sent, 16'd5);
        check("t2.busy_lo", 16'(busy),   16'd0);

        // Tracing rises during SEND_CHAIN: frame finishes, next one waits.
        tracing = 1'b1;
        push(8'd5, 8'd2, 8'd0, 8'h20);
        push(8'd5, 8'd3, 8'd1, 8'h21);
        tracing = 1'b0;
        tick(); bus("t3.lat", 8'hFF, 8'h00);
        tick(); bus("t3.f", 8'd5, 8'd2);
        tracing = 1'b1;
        tick(); bus("t3.c", 8'd5, 8'd0);
        tick(); bus("t3.v", 8'd5, 8'h20);
        tick(); bus("t3.gap", 8'hFF, 8'h00);
        repeat (3) begin
            tick(); bus("t3.held", 8'hFF, 8'h00);
        end
        check("t3.busy", 16'(busy), 16'd1);
        tracing = 1'b0;
        tick(); bus("t3.lat2", 8'hFF, 8'h00);
        tick(); bus("t3.f2", 8'd5, 8'd3);
        tick(); bus("t3.c2", 8'd5, 8'd1);
        tick(); bus("t3.v2", 8'd5, 8'h21);
        tick(); bus("t3.gap2", 8'hFF, 8'h00);
        check("t3.frames", frames_sent, 16'd7);

        // Rejected commands: handshaked, not queued, sticky error.
        check("t4.err0", 16'(cmd_error), 16'd0);
        push(8'hFF, 8'd0, 8'd0, 8'h00);
        check("t4.err1", 16'(cmd_error), 16'd1);
        push(8'd1, 8'd7, 8'd0, 8'h00);
        push(8'd1, 8'd0, 8'd4, 8'h00);
        check("t4.busy", 16'(busy), 16'd0);
        tick(); tick(); bus("t4.idle", 8'hFF, 8'h00);
        check("t4.frames", frames_sent, 16'd7);
        push(8'd6, 8'd1, 8'd2, 8'h33);
        tick(); bus("t4.lat", 8'hFF, 8'h00);
        tick(); bus("t4.f", 8'd6, 8'd1);
        tick(); bus("t4.c", 8'd6, 8'd2);
        tick(); bus("t4.v", 8'd6, 8'h33);
        check("t4.frames2", frames_sent,     16'd8);
        check("t4.sticky",  16'(cmd_error),  16'd1);
        tick(); bus("t4.gap", 8'hFF, 8'h00);

        // Reset during SEND_VALUE with a second command queued.
        tracing = 1'b1;
        push(8'd7, 8'd0, 8'd1, 8'h40);
        push(8'd7, 8'd1, 8'd2, 8'h41);
        tracing = 1'b0;
        tick(); tick(); bus("t5.f", 8'd7, 8'd0);
        tick(); bus("t5.c", 8'd7, 8'd1);
        reset = 1'b1;
        tick(); bus("t5.rst", 8'hFF, 8'h00);
        check("t5.busy",   16'(busy),      16'd0);
        check("t5.frames", frames_sent,    16'd0);
        check("t5.err",    16'(cmd_error), 16'd0);
        reset = 1'b0;
        check("t5.ready",  16'(cmd_ready), 16'd1);
        repeat (6) begin
            tick(); bus("t5.quiet", 8'hFF, 8'h00);
        end
        check("t5.frames2", frames_sent, 16'd0);

        // Frame counter wrap from 16'hFFFF.
        force dut.frames_sent = 16'hFFFF;
        tick();
        release dut.frames_sent;
        tick();
        check("t6.pre", frames_sent, 16'hFFFF);
        push(8'd2, 8'd0, 8'd0, 8'h01);
        repeat (3) tick();
        tick(); bus("t6.v", 8'd2, 8'h01);
        check("t6.wrap", frames_sent, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
